// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if
// Request/grant bundle between a group of requesters and the round-robin
// arbiter that shares one resource among them.
//   req         : one request bit per requester, held while the resource is wanted
//   done        : single-cycle release pulse from the current owner
//   grant       : registered one-hot grant, all zeros when idle
//   grant_idx   : binary index of the set grant bit, 0 when idle
//   grant_valid : high while any grant bit is set
//   timeout     : single-cycle pulse when a grant is revoked by the hold limit
// Modports: master = requester side, slave = arbiter side.
interface rr_grant_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int IDX_WIDTH = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]   req;
   logic                 done;
   logic [NUM_REQ-1:0]   grant;
   logic [IDX_WIDTH-1:0] grant_idx;
   logic                 grant_valid;
   logic                 timeout;

   modport master (
      output req, done,
      input  grant, grant_idx, grant_valid, timeout
   );

   modport slave (
      input  req, done,
      output grant, grant_idx, grant_valid, timeout
   );
endinterface

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter
// Registered round-robin arbiter sharing one resource between NUM_REQ
// requesters. A grant is held until the owner pulses done, drops its
// request, or has held the resource for MAX_HOLD cycles (MAX_HOLD=0 turns
// the hold limit off). Every release spends one cycle in IDLE before the
// next grant, and the priority pointer moves just past the released owner.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : rr_grant_arbiter_if slave modport (req/done in, grant/grant_idx/
//         grant_valid/timeout out, all outputs registered)
module rr_grant_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int IDX_WIDTH  = $clog2(NUM_REQ),
   parameter int MAX_HOLD   = 256,
   parameter int HOLD_WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   rr_grant_arbiter_if.slave  bus
);

   // Last allowed hold count; only meaningful when MAX_HOLD is nonzero.
   localparam logic [HOLD_WIDTH-1:0] HOLD_LAST =
      (MAX_HOLD == 0) ? '0 : HOLD_WIDTH'(MAX_HOLD - 1);
   localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_REQ - 1);

   typedef enum logic {
      IDLE,
      GRANTED
   } state_t;

   state_t                state;
   logic [IDX_WIDTH-1:0]  ptr;
   logic [HOLD_WIDTH-1:0] hold_cnt;
   logic [NUM_REQ-1:0]    grant_q;
   logic [IDX_WIDTH-1:0]  idx_q;
   logic                  valid_q;
   logic                  timeout_q;

   logic                  pick_found;
   logic [IDX_WIDTH-1:0]  pick_idx;
   int                    cand;
   logic [IDX_WIDTH-1:0]  cand_idx;
   logic                  release_normal;
   logic                  hold_hit;
   logic [IDX_WIDTH-1:0]  ptr_next;

   // Scan upward from the pointer with wrap, taking the first requester
   // found. The wrap is an explicit subtract so non-power-of-two NUM_REQ
   // never lands on a nonexistent requester.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = int'(ptr) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_WIDTH'(cand);
         if (!pick_found && bus.req[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Release conditions while granted. A done or request drop in the same
   // cycle as the hold limit counts as a normal release, so timeout only
   // fires when the limit alone ended the grant.
   always_comb begin
      release_normal = bus.done | ~bus.req[idx_q];
      hold_hit       = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
      ptr_next       = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
   end

   // Arbitration state machine with all outputs registered, so grant,
   // grant_idx and grant_valid always move together on one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         grant_q   <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_q  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                  idx_q    <= pick_idx;
                  valid_q  <= 1'b1;
                  hold_cnt <= '0;
                  state    <= GRANTED;
               end
            end
            GRANTED: begin
               if (release_normal || hold_hit) begin
                  grant_q   <= '0;
                  idx_q     <= '0;
                  valid_q   <= 1'b0;
                  timeout_q <= hold_hit & ~release_normal;
                  ptr       <= ptr_next;
                  state     <= IDLE;
               end else if (hold_cnt != '1) begin
                  // Saturate so an unlimited hold never wraps.
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_idx   = idx_q;
   assign bus.grant_valid = valid_q;
   assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter
// Directed bench for rr_grant_arbiter. Two instances share clock, reset and
// request stimulus: dutNoHold (MAX_HOLD=0) for the rotation sequence and
// dutHold (MAX_HOLD=4) for the timeout, release and reset scenarios.
module tb_rr_grant_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int IDX_WIDTH = 2;

   logic               clk;
   logic               rst;
   logic [NUM_REQ-1:0] req;
   logic               done;

   int checkCount;
   int failCount;

   rr_grant_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_WIDTH(IDX_WIDTH)) busNoHold ();
   rr_grant_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_WIDTH(IDX_WIDTH)) busHold ();

   assign busNoHold.req  = req;
   assign busNoHold.done = done;
   assign busHold.req    = req;
   assign busHold.done   = done;

   rr_grant_arbiter #(
      .NUM_REQ(NUM_REQ), .IDX_WIDTH(IDX_WIDTH), .MAX_HOLD(0), .HOLD_WIDTH(16)
   ) dutNoHold (
      .clk(clk),
      .rst(rst),
      .bus(busNoHold.slave)
   );

   rr_grant_arbiter #(
      .NUM_REQ(NUM_REQ), .IDX_WIDTH(IDX_WIDTH), .MAX_HOLD(4), .HOLD_WIDTH(16)
   ) dutHold (
      .clk(clk),
      .rst(rst),
      .bus(busHold.slave)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive req/done, let one rising edge sample them, then settle 1 unit
   // so outputs reflect that edge.
   task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic d);
      req  = r;
      done = d;
      @(posedge clk);
      #1;
   endtask

   // Full output check of the MAX_HOLD=4 instance, including the
   // grant_valid-equals-OR-of-grant invariant.
   task automatic checkHold(input string tag, input logic [3:0] g,
                            input logic [1:0] idx, input logic v, input logic to);
      checkOutput({tag, ".grant"}, 32'(busHold.grant), 32'(g));
      checkOutput({tag, ".idx"}, 32'(busHold.grant_idx), 32'(idx));
      checkOutput({tag, ".valid"}, 32'(busHold.grant_valid), 32'(v));
      checkOutput({tag, ".timeout"}, 32'(busHold.timeout), 32'(to));
      checkOutput({tag, ".validOr"}, 32'(busHold.grant_valid), 32'(|g));
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus('0, 1'b0);
      applyStimulus('0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      checkCount = 0;
      failCount  = 0;
      rst  = 1'b1;
      req  = '0;
      done = 1'b0;
      @(posedge clk);
      #1;

      // Reset state and basic grant/done release with pointer advance.
      doReset();
      checkHold("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      applyStimulus(4'b0101, 1'b0);
      checkHold("first", 4'b0001, 2'd0, 1'b1, 1'b0);
      applyStimulus(4'b0101, 1'b1);
      checkHold("doneRel", 4'b0000, 2'd0, 1'b0, 1'b0);
      applyStimulus(4'b0101, 1'b0);
      checkHold("second", 4'b0100, 2'd2, 1'b1, 1'b0);

      // Dropping the owner's request releases without timeout; done in
      // IDLE with no requests changes nothing.
      applyStimulus(4'b0001, 1'b0);
      checkHold("reqDrop", 4'b0000, 2'd0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      checkHold("idleDone", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Rotation with all requesting and no hold limit.
      doReset();
      for (int k = 0; k < 5; k++) begin
         applyStimulus(4'b1111, 1'b0);
         checkOutput($sformatf("rot%0d.idx", k), 32'(busNoHold.grant_idx), 32'(k % 4));
         checkOutput($sformatf("rot%0d.grant", k), 32'(busNoHold.grant), 32'(1 << (k % 4)));
         checkOutput($sformatf("rot%0d.valid", k), 32'(busNoHold.grant_valid), 32'd1);
         applyStimulus(4'b1111, 1'b1);
         checkOutput($sformatf("rot%0d.gap", k), 32'(busNoHold.grant_valid), 32'd0);
      end

      // Hold limit: four granted cycles, timeout coincident with drop,
      // then re-grant to the sole requester after one IDLE cycle.
      doReset();
      applyStimulus(4'b0010, 1'b0);
      checkHold("hold0", 4'b0010, 2'd1, 1'b1, 1'b0);
      for (int k = 1; k < 4; k++) begin
         applyStimulus(4'b0010, 1'b0);
         checkHold($sformatf("hold%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
      end
      applyStimulus(4'b0010, 1'b0);
      checkHold("timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
      applyStimulus(4'b0010, 1'b0);
      checkHold("regrant", 4'b0010, 2'd1, 1'b1, 1'b0);

      // With requester 0 also waiting, the timed-out owner loses next time.
      for (int k = 1; k < 4; k++) begin
         applyStimulus(4'b0011, 1'b0);
         checkHold($sformatf("hold2_%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
      end
      applyStimulus(4'b0011, 1'b0);
      checkHold("timeout2", 4'b0000, 2'd0, 1'b0, 1'b1);
      applyStimulus(4'b0011, 1'b0);
      checkHold("wrapTo0", 4'b0001, 2'd0, 1'b1, 1'b0);

      // Done and hold limit together: normal release, no timeout.
      for (int k = 1; k < 4; k++) begin
         applyStimulus(4'b0001, 1'b0);
      end
      applyStimulus(4'b0001, 1'b1);
      checkHold("limitAndDone", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Reset mid-grant clears outputs and the pointer.
      doReset();
      applyStimulus(4'b0100, 1'b0);
      applyStimulus(4'b0100, 1'b1);
      applyStimulus(4'b1000, 1'b0);
      checkHold("ptr3", 4'b1000, 2'd3, 1'b1, 1'b0);
      rst = 1'b1;
      applyStimulus(4'b1000, 1'b1);
      checkHold("midRst", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst = 1'b0;
      applyStimulus(4'b1001, 1'b0);
      checkHold("postRst", 4'b0001, 2'd0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule
